// File: rtl/pmp_addr_check_n.sv
// Per-entry PMP address matcher: flags when a 1..4 byte access lies entirely
// inside entry n's OFF/TOR/NA4/NAPOT region; the flag is registered.
module pmp_addr_check_n (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] addr_n,
    input  logic [31:0] addr_n_1,
    input  logic [1:0]  size,
    input  logic [1:0]  a_n,
    output logic        out
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_TOR   = 2'b01,
        MODE_NA4   = 2'b10,
        MODE_NAPOT = 2'b11
    } mode_e;

    logic [32:0] end_addr;
    logic        wrap;
    logic        tor_hit;
    logic [32:0] na4_top;
    logic        na4_hit;
    logic [31:0] napot_mask;
    logic [31:0] napot_base;
    logic [34:0] napot_top;
    logic [32:0] napot_limit;
    logic        napot_hit;
    logic        match;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so each line sees the value just computed above it.
        end_addr = {1'b0, addr} + {31'd0, size};
        wrap     = end_addr[32];

        tor_hit = (addr_n_1 < addr_n) && (addr >= addr_n_1) && (end_addr < {1'b0, addr_n});

        na4_top = {1'b0, addr_n} + 33'd3;
        na4_hit = (addr >= addr_n) && (end_addr <= na4_top);

        // x ^ (x+1) sets bits [t:0], where t is the count of trailing ones.
        napot_mask  = addr_n ^ (addr_n + 32'd1);
        napot_base  = addr_n & ~napot_mask;
        napot_top   = {3'd0, napot_base} + {1'b0, napot_mask, 2'b11};
        napot_limit = (napot_top[34:32] != 3'd0) ? 33'h0_FFFF_FFFF : napot_top[32:0];
        napot_hit   = (addr >= napot_base) && (end_addr <= napot_limit);

        // NOTE: match gets a default before any branch so no path can infer a latch.
        match = 1'b0;
        if (!wrap) begin
            unique case (mode_e'(a_n))
                MODE_OFF:   match = 1'b0;
                MODE_TOR:   match = tor_hit;
                MODE_NA4:   match = na4_hit;
                MODE_NAPOT: match = napot_hit;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) out <= 1'b0;
        else     out <= match;
    end

endmodule

// File: tb/tb_pmp_addr_check_n.sv
// Self-checking bench for pmp_addr_check_n: directed plan steps plus random
// accesses compared against an arithmetic reference model.
module tb_pmp_addr_check_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] addr_n;
    logic [31:0] addr_n_1;
    logic [1:0]  size;
    logic [1:0]  a_n;
    logic        out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] AN  = 32'h1234_567E;
    localparam logic [31:0] AN1 = 32'h1234_566E;

    pmp_addr_check_n dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .addr_n   (addr_n),
        .addr_n_1 (addr_n_1),
        .size     (size),
        .a_n      (a_n),
        .out      (out)
    );

    always #5 clk = ~clk;

    // Reference: region bounds derived directly from the mode rules with wide integers.
    function automatic bit ref_match(input logic [31:0] a, input logic [1:0] s,
                                     input logic [1:0] mode, input logic [31:0] an,
                                     input logic [31:0] an1);
        longint unsigned last, lo, top, len;
        int t;
        last = longint'(a) + longint'(s);
        if (mode == 2'b00 || last > 64'hFFFF_FFFF) return 1'b0;
        case (mode)
            2'b01: return (an1 < an) && (a >= an1) && (last < an);
            2'b10: return (a >= an) && (last <= longint'(an) + 3);
            default: begin
                t = 0;
                while (t < 32 && an[t]) t++;
                if (t >= 32) lo = 0;
                else         lo = longint'(an) & ~((64'd1 << (t + 1)) - 1);
                len = 64'd1 << (t + 3);
                top = lo + len - 1;
                if (top > 64'hFFFF_FFFF) top = 64'hFFFF_FFFF;
                return (a >= lo) && (last <= top);
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: out=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] a, input logic [1:0] s,
                        input logic exp);
        addr = a;
        size = s;
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    initial begin
        logic [31:0] plan_addr [4];
        logic [1:0]  plan_size [3];
        logic [63:0] wide;
        int          k;
        logic        exp;

        plan_addr = '{32'h1234_566D, 32'h1234_566E, 32'h1234_567D, 32'h1234_567E};
        plan_size = '{2'b00, 2'b01, 2'b11};

        rst = 1'b1; addr = AN; addr_n = AN; addr_n_1 = AN1; size = 2'b00; a_n = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", out, 1'b0);
        rst = 1'b0;

        a_n = 2'b00;
        foreach (plan_addr[i])
            foreach (plan_size[j])
                step("off", plan_addr[i], plan_size[j], 1'b0);

        a_n = 2'b01;
        for (int s = 0; s < 4; s++) step("tor_below", 32'h1234_566D, 2'(s), 1'b0);
        for (int s = 0; s < 4; s++) step("tor_low_edge", 32'h1234_566E, 2'(s), 1'b1);
        step("tor_top_s0", 32'h1234_567D, 2'b00, 1'b1);
        step("tor_top_s1", 32'h1234_567D, 2'b01, 1'b0);
        step("tor_top_s3", 32'h1234_567D, 2'b11, 1'b0);
        step("tor_at_hi", 32'h1234_567E, 2'b00, 1'b0);
        addr_n = AN1; addr_n_1 = AN;
        step("tor_swapped", 32'h1234_566E, 2'b00, 1'b0);
        step("tor_swapped2", 32'h1234_5670, 2'b00, 1'b0);
        addr_n = AN; addr_n_1 = AN1;

        a_n = 2'b10;
        step("na4_below", 32'h1234_567D, 2'b00, 1'b0);
        foreach (plan_size[j]) step("na4_base", 32'h1234_567E, plan_size[j], 1'b1);
        step("na4_p1_s0", 32'h1234_567F, 2'b00, 1'b1);
        step("na4_p1_s1", 32'h1234_567F, 2'b01, 1'b1);
        step("na4_p1_s3", 32'h1234_567F, 2'b11, 1'b0);
        step("na4_p2_s0", 32'h1234_5680, 2'b00, 1'b1);
        step("na4_p2_s1", 32'h1234_5680, 2'b01, 1'b1);
        step("na4_p2_s3", 32'h1234_5680, 2'b11, 1'b0);
        step("na4_p3_s0", 32'h1234_5681, 2'b00, 1'b1);
        step("na4_p3_s1", 32'h1234_5681, 2'b01, 1'b0);
        step("na4_above", 32'h1234_5682, 2'b00, 1'b0);

        a_n = 2'b11;
        step("napot_below", 32'h1234_567D, 2'b00, 1'b0);
        step("napot_base_s3", 32'h1234_567E, 2'b11, 1'b1);
        step("napot_top_s0", 32'h1234_5685, 2'b00, 1'b1);
        step("napot_top_s1", 32'h1234_5685, 2'b01, 1'b0);
        step("napot_above", 32'h1234_5686, 2'b00, 1'b0);
        addr_n = 32'hFFFF_FFFF;
        step("napot_full_top", 32'hFFFF_FFFC, 2'b11, 1'b1);
        step("napot_wrap", 32'hFFFF_FFFE, 2'b11, 1'b0);

        // Reset overrides a matching TOR access, then latency and mid-cycle hold.
        a_n = 2'b01; addr_n = AN; addr_n_1 = AN1; rst = 1'b1;
        step("rst_override", 32'h1234_5670, 2'b00, 1'b0);
        rst = 1'b0;
        step("rst_release", 32'h1234_5670, 2'b00, 1'b1);
        @(negedge clk);
        addr = 32'h1234_5690;
        #1;
        check("hold_midcycle", out, 1'b1);
        @(posedge clk);
        #1;
        check("after_change", out, 1'b0);

        for (int it = 0; it < 400; it++) begin
            a_n = 2'($urandom_range(0, 3));
            wide = {$urandom, $urandom};
            if (a_n == 2'b11) begin
                k = $urandom_range(0, 32);
                wide = wide | ((64'd1 << k) - 1);
                if (k < 32) wide = wide & ~(64'd1 << k);
            end
            addr_n   = wide[31:0];
            addr_n_1 = ($urandom_range(0, 3) == 0) ? $urandom : addr_n - $urandom_range(0, 40);
            case ($urandom_range(0, 3))
                0:       addr = addr_n + $urandom_range(0, 12) - 4;
                1:       addr = addr_n_1 + $urandom_range(0, 12) - 4;
                2:       addr = 32'hFFFF_FFF8 + $urandom_range(0, 7);
                default: addr = $urandom;
            endcase
            if (a_n == 2'b11 && $urandom_range(0, 1) == 1)
                addr = (addr_n & ~(addr_n ^ (addr_n + 32'd1))) + $urandom_range(0, 20);
            size = 2'($urandom_range(0, 3));
            rst  = ($urandom_range(0, 15) == 0);
            exp  = rst ? 1'b0 : ref_match(addr, size, a_n, addr_n, addr_n_1);
            @(posedge clk);
            #1;
            check("random", out, exp);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
